// File: rtl/tspp_fetch_stage.sv
// Fetch stage: owns the PC, reads the instruction bus and hands instructions to execute through a
// one-entry output register backed by a one-entry skid buffer. Redirects flush wrong-path work.
module tspp_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_ren_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_busy_i,
    input  logic [31:0] imem_rdata_i,
    input  logic [31:0] brj_addr_i,
    input  logic        pc_redirect_i,
    input  logic        ex_stall_i,
    output logic        fe_valid_o,
    output logic [31:0] fe_pc_o,
    output logic [31:0] fe_pc4_o,
    output logic [31:0] fe_instr_o,
    output logic        fe_misaligned_o
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] stale_q, stale_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_mis_q, skid_mis_d;
    logic        fe_valid_q, fe_valid_d;
    logic [31:0] fe_pc_q, fe_pc_d;
    logic [31:0] fe_instr_q, fe_instr_d;
    logic        fe_mis_q, fe_mis_d;

    logic out_free;
    logic pc_mis;

    assign out_free = !fe_valid_q || !ex_stall_i;
    assign pc_mis   = (pc_q[1:0] != 2'b00);

    // DISCARD keeps presenting the stale address so the bus read can complete undisturbed.
    always_comb begin
        imem_ren_o  = 1'b0;
        imem_addr_o = pc_q;
        if (rst_ni) begin
            unique case (state_q)
                StFetch:   imem_ren_o = !pc_mis;
                StHold:    imem_ren_o = 1'b0;
                StDiscard: begin
                    imem_ren_o  = 1'b1;
                    imem_addr_o = stale_q;
                end
                default:   imem_ren_o = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_mis_d   = skid_mis_q;
        fe_valid_d   = ex_stall_i ? fe_valid_q : 1'b0;
        fe_pc_d      = fe_pc_q;
        fe_instr_d   = fe_instr_q;
        fe_mis_d     = fe_mis_q;

        if (pc_redirect_i) begin
            fe_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = brj_addr_i;
            stale_d      = pc_q;
            if (state_q == StFetch && imem_ren_o && imem_busy_i) begin
                state_d = StDiscard;
            end else begin
                state_d = StFetch;
            end
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (pc_mis) begin
                        if (out_free) begin
                            fe_valid_d = 1'b1;
                            fe_mis_d   = 1'b1;
                            fe_instr_d = 32'h0;
                            fe_pc_d    = pc_q;
                        end
                    end else if (!imem_busy_i) begin
                        pc_d = pc_q + 32'd4;
                        if (out_free) begin
                            fe_valid_d = 1'b1;
                            fe_mis_d   = 1'b0;
                            fe_instr_d = imem_rdata_i;
                            fe_pc_d    = pc_q;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_mis_d   = 1'b0;
                            skid_instr_d = imem_rdata_i;
                            skid_pc_d    = pc_q;
                            state_d      = StHold;
                        end
                    end
                end
                StHold: begin
                    if (!ex_stall_i) begin
                        fe_valid_d   = skid_valid_q;
                        fe_mis_d     = skid_mis_q;
                        fe_instr_d   = skid_instr_q;
                        fe_pc_d      = skid_pc_q;
                        skid_valid_d = 1'b0;
                        state_d      = StFetch;
                    end
                end
                StDiscard: begin
                    if (!imem_busy_i) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            stale_q      <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_mis_q   <= 1'b0;
            fe_valid_q   <= 1'b0;
            fe_pc_q      <= 32'h0;
            fe_instr_q   <= 32'h0;
            fe_mis_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_mis_q   <= skid_mis_d;
            fe_valid_q   <= fe_valid_d;
            fe_pc_q      <= fe_pc_d;
            fe_instr_q   <= fe_instr_d;
            fe_mis_q     <= fe_mis_d;
        end
    end

    assign fe_valid_o      = fe_valid_q;
    assign fe_pc_o         = fe_pc_q;
    assign fe_pc4_o        = fe_pc_q + 32'd4;
    assign fe_instr_o      = fe_instr_q;
    assign fe_misaligned_o = fe_mis_q;

endmodule

// File: tb/tb_tspp_fetch_stage.sv
// Directed bench for tspp_fetch_stage: a small instruction memory with configurable wait states
// and a linear sequence of reset, stall, redirect, misalignment and wrap scenarios.
module tb_tspp_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy;
    logic [31:0] imem_rdata;
    logic [31:0] brj_addr;
    logic        pc_redirect;
    logic        ex_stall;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_pc4;
    logic [31:0] fe_instr;
    logic        fe_misaligned;

    int checks = 0;
    int errors = 0;
    int waits  = 0;
    int wcnt   = 0;

    tspp_fetch_stage #(.RESET_PC(32'h0000_0200)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .imem_ren_o      (imem_ren),
        .imem_addr_o     (imem_addr),
        .imem_busy_i     (imem_busy),
        .imem_rdata_i    (imem_rdata),
        .brj_addr_i      (brj_addr),
        .pc_redirect_i   (pc_redirect),
        .ex_stall_i      (ex_stall),
        .fe_valid_o      (fe_valid),
        .fe_pc_o         (fe_pc),
        .fe_pc4_o        (fe_pc4),
        .fe_instr_o      (fe_instr),
        .fe_misaligned_o (fe_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Each read stays busy for `waits` cycles, then completes.
    assign imem_busy  = imem_ren && (wcnt < waits);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (!rst_n || !imem_ren || !imem_busy) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk1({tag, "_valid"}, fe_valid, 1'b1);
        chk({tag, "_pc"}, fe_pc, pc);
        chk({tag, "_pc4"}, fe_pc4, pc + 32'd4);
        chk({tag, "_instr"}, fe_instr, mem_word(pc));
        chk1({tag, "_mis"}, fe_misaligned, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pc_redirect = 1'b0; brj_addr = 32'h0; ex_stall = 1'b0; waits = 0;
        tick(); tick();
        // Reset values
        chk1("rst_valid", fe_valid, 1'b0);
        chk("rst_pc", fe_pc, 32'h0);
        chk("rst_pc4", fe_pc4, 32'h4);
        chk("rst_instr", fe_instr, 32'h0);
        chk1("rst_mis", fe_misaligned, 1'b0);
        chk1("rst_ren", imem_ren, 1'b0);

        // Zero-wait streaming
        rst_n = 1'b1;
        #1;
        chk1("zw_ren", imem_ren, 1'b1);
        chk("zw_addr", imem_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("zw", 32'h200 + 32'(4 * i));
            chk("zw_next_addr", imem_addr, 32'h204 + 32'(4 * i));
        end

        // Three wait states per read
        rst_n = 1'b0; waits = 3;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ws_addr_hold", imem_addr, 32'h200);
            chk1("ws_ren", imem_ren, 1'b1);
            chk1("ws_valid_lo", fe_valid, 1'b0);
            tick();
        end
        chk_out("ws_first", 32'h200);
        chk("ws_addr_next", imem_addr, 32'h204);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("ws_pulse_lo", fe_valid, 1'b0);
        end
        tick();
        chk_out("ws_second", 32'h204);

        // Stall with the skid buffer filling
        waits = 0; ex_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_pc", fe_pc, 32'h204);
            chk1("stall_valid", fe_valid, 1'b1);
            chk1("stall_ren", imem_ren, 1'b0);
        end
        ex_stall = 1'b0;
        tick();
        chk_out("unstall_skid", 32'h208);
        chk1("unstall_ren", imem_ren, 1'b1);
        chk("unstall_addr", imem_addr, 32'h20C);
        tick();
        chk_out("unstall_next", 32'h20C);
        chk("unstall_addr2", imem_addr, 32'h210);

        // Redirect while a read of 0x210 is in flight
        waits = 3; pc_redirect = 1'b1; brj_addr = 32'h1000;
        #1;
        chk1("rd_busy", imem_busy, 1'b1);
        tick();
        pc_redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("rd_valid_lo", fe_valid, 1'b0);
            chk("rd_stale_addr", imem_addr, 32'h210);
            chk1("rd_stale_ren", imem_ren, 1'b1);
            tick();
        end
        chk("rd_new_addr", imem_addr, 32'h1000);
        chk1("rd_new_ren", imem_ren, 1'b1);
        chk1("rd_discarded", fe_valid, 1'b0);
        waits = 0;
        tick();
        chk_out("rd_target", 32'h1000);

        // Redirect together with stall while the skid buffer is full
        ex_stall = 1'b1;
        tick();
        chk1("rs_hold_ren", imem_ren, 1'b0);
        chk("rs_hold_pc", fe_pc, 32'h1000);
        pc_redirect = 1'b1; brj_addr = 32'h2000;
        tick();
        pc_redirect = 1'b0; ex_stall = 1'b0;
        chk1("rs_flushed", fe_valid, 1'b0);
        chk("rs_addr", imem_addr, 32'h2000);
        tick();
        chk_out("rs_target", 32'h2000);

        // Misaligned redirect target
        pc_redirect = 1'b1; brj_addr = 32'h1002;
        tick();
        pc_redirect = 1'b0;
        chk1("mis_ren0", imem_ren, 1'b0);
        chk1("mis_flush", fe_valid, 1'b0);
        tick();
        chk1("mis_valid", fe_valid, 1'b1);
        chk1("mis_flag", fe_misaligned, 1'b1);
        chk("mis_pc", fe_pc, 32'h1002);
        chk("mis_instr", fe_instr, 32'h0);
        chk("mis_pc4", fe_pc4, 32'h1006);
        chk1("mis_ren1", imem_ren, 1'b0);
        tick();
        chk1("mis_ren2", imem_ren, 1'b0);
        chk("mis_pc_hold", fe_pc, 32'h1002);

        // PC wrap at the top of the address space
        pc_redirect = 1'b1; brj_addr = 32'hFFFF_FFFC;
        tick();
        pc_redirect = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap_out", 32'hFFFF_FFFC);
        chk("wrap_pc4", fe_pc4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk1("wrap_next_ren", imem_ren, 1'b1);

        // Reset mid-read while the output is held by a stall
        waits = 3; ex_stall = 1'b1; rst_n = 1'b0;
        #1;
        chk1("mr_ren_comb", imem_ren, 1'b0);
        tick();
        chk1("mr_valid", fe_valid, 1'b0);
        chk1("mr_ren", imem_ren, 1'b0);
        chk("mr_pc", fe_pc, 32'h0);
        rst_n = 1'b1; ex_stall = 1'b0; waits = 0;
        #1;
        chk1("mr_restart_ren", imem_ren, 1'b1);
        chk("mr_restart_addr", imem_addr, 32'h200);
        tick();
        chk_out("mr_restart_out", 32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
